// File: rtl/mmult_opt_mdc_job_sequencer_pkg.sv
// Shared definitions for the mmult multi-dataflow job sequencer.
// Contents:
//   - default widths for the output counter, the tile repeat counter and the
//     watchdog;
//   - seq_state_t, the sequencer state encoding;
//   - seq_cfg_t, the job descriptor {n_out, n_rep} at the default widths;
//   - seq_is_busy(), the state decode behind busy_o.
package mmult_opt_mdc_seq_package;

    localparam int unsigned SEQ_CNT_W_DEF  = 16;
    localparam int unsigned SEQ_REP_W_DEF  = 8;
    localparam int unsigned SEQ_WDOG_W_DEF = 12;

    typedef enum logic [1:0] {
        SEQ_IDLE   = 2'd0,
        SEQ_START  = 2'd1,
        SEQ_RUN    = 2'd2,
        SEQ_FINISH = 2'd3
    } seq_state_t;

    typedef struct packed {
        logic [SEQ_CNT_W_DEF-1:0] n_out;
        logic [SEQ_REP_W_DEF-1:0] n_rep;
    } seq_cfg_t;

    function automatic logic seq_is_busy(input seq_state_t state);
        return (state != SEQ_IDLE);
    endfunction

endpackage

// File: rtl/mmult_opt_mdc_job_sequencer_counter.sv
// Loadable, clearable up-counter with a terminal-count compare.
// The priority order is clear, then load, then increment. The counter wraps
// only when incremented past all-ones. The caller decides when to stop
// incrementing by using tc_o.
// Ports:
//   clk_i, rst_ni     clock, asynchronous active-low reset
//   clr_i             synchronous clear to zero
//   load_i/load_val_i synchronous load
//   inc_i             increment by one
//   tc_val_i          terminal value that the count is compared against
//   cnt_o             current count (registered)
//   tc_o              cnt_o == tc_val_i, compared over the full width
module mmult_opt_mdc_seq_counter
    import mmult_opt_mdc_seq_package::*;
#(
    parameter int unsigned W = SEQ_CNT_W_DEF
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clr_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         inc_i,
    input  logic [W-1:0] tc_val_i,
    output logic [W-1:0] cnt_o,
    output logic         tc_o
);

    logic [W-1:0] cnt_d;
    logic [W-1:0] cnt_q;

    // Next count: clear beats load, and load beats increment.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (inc_i) begin
            cnt_d = cnt_q + W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
    assign tc_o  = (cnt_q == tc_val_i);

endmodule

// File: rtl/mmult_opt_mdc_job_sequencer.sv
// Job sequencer for the multi-dataflow mmult kernel adapter.
// It accepts a descriptor of {outputs per tile, number of tiles}. For each
// tile it issues one kernel start pulse, opens the input streams and counts
// kernel done pulses. After the last tile it pulses evt_done_o once.
// Optional build macro: MMULT_OPT_MDC_SEQ_WATCHDOG_EN. When it is defined,
// the job aborts with err_o if no done pulse arrives before the
// WDOG_W-bit watchdog saturates in RUN.
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   clear_i                synchronous abort back to IDLE
//   cfg_valid_i/ready_o    descriptor handshake (ready only in IDLE)
//   cfg_n_out_i/n_rep_i    outputs per tile / number of tiles
//   kernel_start_o         one-cycle start per tile
//   kernel_done_i          one pulse per completed output
//   in_enable_o            input stream gate, high in RUN
//   busy_o                 not IDLE
//   evt_done_o, err_o      end-of-job / error pulses
//   cnt_out_o, rep_o       progress in the current tile / tile index
module mmult_opt_mdc_job_sequencer
    import mmult_opt_mdc_seq_package::*;
#(
    parameter int unsigned CNT_W  = SEQ_CNT_W_DEF,
    parameter int unsigned REP_W  = SEQ_REP_W_DEF,
    parameter int unsigned WDOG_W = SEQ_WDOG_W_DEF
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             cfg_valid_i,
    output logic             cfg_ready_o,
    input  logic [CNT_W-1:0] cfg_n_out_i,
    input  logic [REP_W-1:0] cfg_n_rep_i,
    output logic             kernel_start_o,
    input  logic             kernel_done_i,
    output logic             in_enable_o,
    output logic             busy_o,
    output logic             evt_done_o,
    output logic             err_o,
    output logic [CNT_W-1:0] cnt_out_o,
    output logic [REP_W-1:0] rep_o
);

    seq_state_t       state_d, state_q;
    logic [CNT_W-1:0] n_out_d, n_out_q;
    logic [REP_W-1:0] n_rep_d, n_rep_q;
    logic             kernel_start_d, kernel_start_q;
    logic             in_enable_d, in_enable_q;
    logic             evt_done_d, evt_done_q;
    logic             err_d, err_q;

    logic             cnt_clr_s, cnt_inc_s, cnt_tc_s;
    logic             rep_clr_s, rep_inc_s, rep_tc_s;
    logic [WDOG_W-1:0] wdog_cnt_s;
    logic             wdog_expired_s;

    // Outputs of the current tile. It ends on the done pulse that arrives at
    // n_out-1, so cnt_out never reaches n_out.
    mmult_opt_mdc_seq_counter #(.W(CNT_W)) u_cnt_out (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .clr_i      (cnt_clr_s),
        .load_i     (1'b0),
        .load_val_i ({CNT_W{1'b0}}),
        .inc_i      (cnt_inc_s),
        .tc_val_i   (n_out_q - CNT_W'(1)),
        .cnt_o      (cnt_out_o),
        .tc_o       (cnt_tc_s)
    );

    mmult_opt_mdc_seq_counter #(.W(REP_W)) u_rep (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .clr_i      (rep_clr_s),
        .load_i     (1'b0),
        .load_val_i ({REP_W{1'b0}}),
        .inc_i      (rep_inc_s),
        .tc_val_i   (n_rep_q - REP_W'(1)),
        .cnt_o      (rep_o),
        .tc_o       (rep_tc_s)
    );

`ifdef MMULT_OPT_MDC_SEQ_WATCHDOG_EN
    logic wdog_clr_s;
    logic wdog_tc_s;

    // The watchdog runs only in RUN. It restarts on every done pulse and is
    // held at zero in START, so every RUN entry begins from zero.
    always_comb begin
        wdog_clr_s = clear_i || (state_q != SEQ_RUN) || kernel_done_i;
    end

    mmult_opt_mdc_seq_counter #(.W(WDOG_W)) u_wdog (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .clr_i      (wdog_clr_s),
        .load_i     (1'b0),
        .load_val_i ({WDOG_W{1'b0}}),
        .inc_i      (state_q == SEQ_RUN),
        .tc_val_i   ({WDOG_W{1'b1}}),
        .cnt_o      (wdog_cnt_s),
        .tc_o       (wdog_tc_s)
    );

    assign wdog_expired_s = wdog_tc_s && (wdog_cnt_s == {WDOG_W{1'b1}});
`else
    // Without a watchdog the count stays at zero and never expires.
    assign wdog_cnt_s     = {WDOG_W{1'b0}};
    assign wdog_expired_s = &wdog_cnt_s;
`endif

    // Next-state logic and counter control. The registered output pulses
    // are derived from the next state, so they line up with the state.
    always_comb begin
        state_d   = state_q;
        n_out_d   = n_out_q;
        n_rep_d   = n_rep_q;
        err_d     = 1'b0;
        cnt_clr_s = 1'b0;
        cnt_inc_s = 1'b0;
        rep_clr_s = 1'b0;
        rep_inc_s = 1'b0;

        if (clear_i) begin
            // Abort wins over everything, including a descriptor handshake
            // in the same cycle.
            state_d   = SEQ_IDLE;
            cnt_clr_s = 1'b1;
            rep_clr_s = 1'b1;
        end else begin
            case (state_q)
                SEQ_IDLE: begin
                    if (cfg_valid_i) begin
                        n_out_d = cfg_n_out_i;
                        n_rep_d = cfg_n_rep_i;
                        if ((cfg_n_out_i == {CNT_W{1'b0}}) || (cfg_n_rep_i == {REP_W{1'b0}})) begin
                            err_d = 1'b1;
                        end else begin
                            state_d   = SEQ_START;
                            cnt_clr_s = 1'b1;
                            rep_clr_s = 1'b1;
                        end
                    end else begin
                        state_d = SEQ_IDLE;
                    end
                end
                SEQ_START: begin
                    state_d = SEQ_RUN;
                end
                SEQ_RUN: begin
                    if (kernel_done_i) begin
                        if (cnt_tc_s) begin
                            if (rep_tc_s) begin
                                state_d = SEQ_FINISH;
                            end else begin
                                // Next tile: the START cycle is the single
                                // cycle with the inputs gated between tiles.
                                state_d   = SEQ_START;
                                cnt_clr_s = 1'b1;
                                rep_inc_s = 1'b1;
                            end
                        end else begin
                            cnt_inc_s = 1'b1;
                        end
                    end else if (wdog_expired_s) begin
                        state_d   = SEQ_IDLE;
                        err_d     = 1'b1;
                        cnt_clr_s = 1'b1;
                        rep_clr_s = 1'b1;
                    end else begin
                        state_d = SEQ_RUN;
                    end
                end
                SEQ_FINISH: begin
                    state_d = SEQ_IDLE;
                end
                default: begin
                    state_d = SEQ_IDLE;
                end
            endcase
        end

        kernel_start_d = (state_d == SEQ_START);
        in_enable_d    = (state_d == SEQ_RUN);
        evt_done_d     = (state_d == SEQ_FINISH);
    end

    // State, latched descriptor and registered output pulses.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= SEQ_IDLE;
            n_out_q        <= '0;
            n_rep_q        <= '0;
            kernel_start_q <= 1'b0;
            in_enable_q    <= 1'b0;
            evt_done_q     <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            n_out_q        <= n_out_d;
            n_rep_q        <= n_rep_d;
            kernel_start_q <= kernel_start_d;
            in_enable_q    <= in_enable_d;
            evt_done_q     <= evt_done_d;
            err_q          <= err_d;
        end
    end

    assign cfg_ready_o    = (state_q == SEQ_IDLE);
    assign busy_o         = seq_is_busy(state_q);
    assign kernel_start_o = kernel_start_q;
    assign in_enable_o    = in_enable_q;
    assign evt_done_o     = evt_done_q;
    assign err_o          = err_q;

endmodule
